// File: rtl/fifo_nibble_uart_tx_if.sv
// FIFO read-side bundle between the synchronous FIFO and its serial consumer.
// master = consumer (issues pops), slave = FIFO (supplies flag and data).
interface fifo_nibble_uart_tx_if #(
   parameter int DATA_W = 4
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      input  fifo_rd_en
   );
endinterface

// File: rtl/fifo_nibble_uart_tx.sv
// Pops words from a registered-read FIFO and sends them as start/LSB-first/stop frames.
// Define FIFO_UART_PARITY_EN to append an even-parity bit after the data bits.
module fifo_nibble_uart_tx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_nibble_uart_tx_if.master fifo,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef FIFO_UART_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, POP, LOAD, START, DATA, PARITY, STOP
   } state_e;
`else
   typedef enum logic [2:0] {
      IDLE, POP, LOAD, START, DATA, STOP
   } state_e;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              tx_out_q, tx_out_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;
`ifdef FIFO_UART_PARITY_EN
   logic              parity_q, parity_d;
`endif

   assign bit_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      bit_d   = bit_q;
`ifdef FIFO_UART_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rd_en_q) state_d = POP;
         end
         POP: state_d = LOAD;
         LOAD: begin
            shift_d = fifo.fifo_rd_data;
            div_d   = '0;
            bit_d   = '0;
`ifdef FIFO_UART_PARITY_EN
            parity_d = ^fifo.fifo_rd_data;
`endif
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               div_d   = '0;
               state_d = DATA;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               div_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef FIFO_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
`ifdef FIFO_UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               div_d   = '0;
               state_d = STOP;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         state_d = IDLE;
         shift_d = '0;
         div_d   = '0;
         bit_d   = '0;
`ifdef FIFO_UART_PARITY_EN
         parity_d = 1'b0;
`endif
      end

      // Outputs are decoded from the next state so they change with it.
      unique case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
`ifdef FIFO_UART_PARITY_EN
         PARITY:  tx_out_d = parity_d;
`endif
         default: tx_out_d = 1'b1;
      endcase

      busy_d  = (state_d != IDLE);
      done_d  = (state_d == STOP) && (div_d == DIV_LAST);
      rd_en_d = (state_d == IDLE) && !fifo.fifo_empty;

      if (rst) begin
         tx_out_d = 1'b1;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         rd_en_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_out_q <= tx_out_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_UART_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   assign fifo.fifo_rd_en = rd_en_q;
   assign tx_out          = tx_out_q;
   assign busy            = busy_q;
   assign frame_done      = done_q;

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Directed bench for fifo_nibble_uart_tx with a FIFO model and a frame scoreboard.
// Build with FIFO_UART_PARITY_EN defined to cover the parity variant.
module tb_fifo_nibble_uart_tx;

   localparam int DW  = 4;
   localparam int CPB = 2;
`ifdef FIFO_UART_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NBITS     = DW + 2 + PAR;
   localparam int FRAME_CYC = NBITS * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_out, busy, frame_done;

   logic          fe  = 1'b1;
   logic [DW-1:0] rdd = '0;

   fifo_nibble_uart_tx_if #(.DATA_W(DW)) ifc ();
   assign ifc.fifo_empty   = fe;
   assign ifc.fifo_rd_data = rdd;

   fifo_nibble_uart_tx #(
      .DATA_W      (DW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo      (ifc),
      .tx_out    (tx_out),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int pops        = 0;
   int frames      = 0;
   int frame_target = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic mask_on = 1'b0;
   logic tog     = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: registered read, data appears the cycle after the pop.
   always @(posedge clk) begin
      if (ifc.fifo_rd_en && fq.size() > 0) rdd <= fq.pop_front();
   end

   // Empty flag, optionally scrambled while a frame is in flight.
   always @(posedge clk) begin
      #2;
      tog = ~tog;
      fe = (fq.size() == 0) ^ (mask_on && busy && !frame_done && tog);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return ifc.fifo_rd_en == 1'b1;
         1:       return frame_done == 1'b1;
         2:       return tx_out == 1'b0;
         default: return frames >= frame_target;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (cond(sel)) return;
         tick();
      end
      chk({tag, "_timeout"}, 64'(0), 64'(1));
   endtask

   function automatic logic [63:0] exp_levels(input logic [DW-1:0] w);
      logic [63:0] v = '0;
      int p = 0;
      logic b;
      for (int k = 0; k < NBITS; k++) begin
         if (k == 0) b = 1'b0;
         else if (k <= DW) b = w[k-1];
         else if (PAR != 0 && k == DW + 1) b = ^w;
         else b = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            v[p] = b;
            p++;
         end
      end
      return v;
   endfunction

   // Frame monitor: collects one level per cycle and scores the whole frame.
   logic          in_frame = 1'b0;
   logic          prev_rd  = 1'b0;
   int            fcyc     = 0;
   logic [63:0]   lv, dn, bz;
   logic [DW-1:0] cur;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         prev_rd  = 1'b0;
      end else begin
         if (prev_rd) begin
            chk("rd_en_single", 64'(ifc.fifo_rd_en), 64'(0));
            chk("busy_after_pop", 64'(busy), 64'(1));
         end
         if (ifc.fifo_rd_en) begin
            pops++;
            chk("rd_en_when_empty", 64'(ifc.fifo_empty), 64'(0));
            chk("rd_en_when_busy", 64'(busy), 64'(0));
         end
         if (frame_done) frames++;
         prev_rd = ifc.fifo_rd_en;
         if (!in_frame && tx_out == 1'b0) begin
            in_frame = 1'b1;
            fcyc = 0;
            lv = '0;
            dn = '0;
            bz = '0;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 64'(1), 64'(0));
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
            end
         end
         if (in_frame) begin
            lv[fcyc] = tx_out;
            dn[fcyc] = frame_done;
            bz[fcyc] = busy;
            fcyc++;
            if (fcyc == FRAME_CYC) begin
               chk("frame_bits", lv, exp_levels(cur));
               chk("frame_done_pos", dn, 64'(1) << (FRAME_CYC - 1));
               chk("frame_busy", bz, (64'(1) << FRAME_CYC) - 64'(1));
               in_frame = 1'b0;
            end
         end
      end
   end

   initial begin
      int t_start, t_done, p0, f0;

      // Reset, then idle with an empty FIFO.
      rst = 1'b1;
      tick();
      tick();
      chk("rst_tx", 64'(tx_out), 64'(1));
      chk("rst_rd_en", 64'(ifc.fifo_rd_en), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(frame_done), 64'(0));
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle_tx", 64'(tx_out), 64'(1));
         chk("idle_rd_en", 64'(ifc.fifo_rd_en), 64'(0));
         chk("idle_busy", 64'(busy), 64'(0));
      end

      // Single word.
      p0 = pops;
      push(4'b1010);
      wait_for("t2_pop", 0, 10);
      wait_for("t2_start", 2, 10);
      t_start = cyc;
      wait_for("t2_done", 1, 4 * FRAME_CYC);
      t_done = cyc;
      chk("t2_frame_len", 64'(t_done - t_start), 64'(FRAME_CYC - 1));
      repeat (6) tick();
      chk("t2_pop_count", 64'(pops - p0), 64'(1));
      chk("t2_idle_tx", 64'(tx_out), 64'(1));

      // Back-to-back words.
      push(4'b1010);
      push(4'b1100);
      wait_for("t3_pop1", 0, 10);
      wait_for("t3_done1", 1, 4 * FRAME_CYC);
      t_done = cyc;
      tick();
      wait_for("t3_pop2", 0, 10);
      chk("t3_pop_gap", 64'(cyc - t_done), 64'(1));
      wait_for("t3_start2", 2, 10);
      chk("t3_start_gap", 64'(cyc - t_done), 64'(4));
      tick();
      wait_for("t3_done2", 1, 4 * FRAME_CYC);
      repeat (6) tick();

      // Parity patterns (plain data patterns in the default build).
      f0 = frames;
      push(4'b1011);
      push(4'b1010);
      wait_for("t4_start", 2, 10);
      t_start = cyc;
      wait_for("t4_done", 1, 4 * FRAME_CYC);
      chk("t4_frame_len", 64'(cyc - t_start), 64'(FRAME_CYC - 1));
      frame_target = f0 + 2;
      wait_for("t4_frames", 3, 4 * FRAME_CYC);
      repeat (6) tick();

      // Reset during data bit 2 of an all-zero word.
      push(4'b0000);
      wait_for("t5_start", 2, 10);
      repeat (3 * CPB) tick();
      chk("t5_pre_tx", 64'(tx_out), 64'(0));
      chk("t5_pre_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      chk("t5_rst_tx", 64'(tx_out), 64'(1));
      chk("t5_rst_busy", 64'(busy), 64'(0));
      chk("t5_rst_rd_en", 64'(ifc.fifo_rd_en), 64'(0));
      rst = 1'b0;
      p0 = pops;
      repeat (20) tick();
      chk("t5_no_repop", 64'(pops - p0), 64'(0));
      chk("t5_idle_tx", 64'(tx_out), 64'(1));
      chk("t5_idle_busy", 64'(busy), 64'(0));

      // Five random words with the empty flag scrambled mid-frame.
      p0 = pops;
      f0 = frames;
      mask_on = 1'b1;
      for (int i = 0; i < 5; i++) push(DW'($urandom_range(0, 15)));
      frame_target = f0 + 5;
      wait_for("t6_frames", 3, 5 * (FRAME_CYC + 8) + 20);
      mask_on = 1'b0;
      repeat (6) tick();
      chk("t6_pops", 64'(pops - p0), 64'(5));
      chk("t6_frames", 64'(frames - f0), 64'(5));
      chk("t6_pops_eq_frames", 64'(pops - p0), 64'(frames - f0));
      chk("sb_drained", 64'(exp_q.size()), 64'(0));
      chk("fifo_drained", 64'(fq.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
